// File: rtl/counter_pkg.sv
// Shared types and field widths for the stopwatch counter and its controller.
package counter_pkg;

   localparam int unsigned MIN_W  = 6;
   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MS10_W = 7;

   // Encoding is visible on state_o, so the values are fixed.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StLap  = 2'd2,
      StStop = 2'd3
   } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Button, live-count, counter-control and display signals of counter_ctrl.
interface counter_ctrl_if;
   import counter_pkg::*;

   logic              start_stop_btn;
   logic              lap_reset_btn;
   logic [MIN_W-1:0]  min_i;
   logic [SEC_W-1:0]  sec_i;
   logic [MS10_W-1:0] ms_10_i;
   logic              cnt_en_o;
   logic              cnt_clr_o;
   logic [MIN_W-1:0]  min_o;
   logic [SEC_W-1:0]  sec_o;
   logic [MS10_W-1:0] ms_10_o;
   logic [1:0]        state_o;

   // Controller side.
   modport slave (
      input  start_stop_btn, lap_reset_btn, min_i, sec_i, ms_10_i,
      output cnt_en_o, cnt_clr_o, min_o, sec_o, ms_10_o, state_o
   );

   // Environment side: buttons and counter_core drive, display consumes.
   modport master (
      output start_stop_btn, lap_reset_btn, min_i, sec_i, ms_10_i,
      input  cnt_en_o, cnt_clr_o, min_o, sec_o, ms_10_o, state_o
   );

endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> debouncer -> one-cycle press pulse.
// After reset the debouncer stays disarmed until the button has been seen low
// for DEBOUNCE_CYCLES cycles, so a button held through reset never fires.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [1:0]      vld_q;
   logic            arm_q, arm_d;
   logic            acc_q, acc_d;
   logic            acc_dly_q;
   logic            pulse_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Synchronizer; vld_q marks when sync2_q reflects the pin rather than reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         vld_q   <= 2'b00;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         vld_q   <= {vld_q[0], 1'b1};
      end
   end

   // Stability counter: arms on a stable low, then tracks the accepted level.
   always_comb begin
      cnt_d = '0;
      acc_d = acc_q;
      arm_d = arm_q;
      if (!arm_q) begin
         if (vld_q[1] && !sync2_q) begin
            if (cnt_q == CntMax) begin
               arm_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end else if (sync2_q != acc_q) begin
         if (cnt_q == CntMax) begin
            acc_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce state and registered rising-edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         arm_q     <= 1'b0;
         acc_dly_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         arm_q     <= arm_d;
         acc_dly_q <= acc_q;
         pulse_q   <= acc_q & ~acc_dly_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/counter_ctrl.sv
// Stopwatch controller: debounced buttons drive an IDLE/RUN/LAP/STOP FSM that
// enables and clears counter_core and selects a live or lap-frozen display.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input logic            clk,
   input logic            rst,
   counter_ctrl_if.slave  bus_io
);

   logic              ss_pulse, lap_pulse;
   state_e            state_q, state_d;
   logic              clr_q, clr_d;
   logic              lap_cap;
   logic [MIN_W-1:0]  lap_min_q;
   logic [SEC_W-1:0]  lap_sec_q;
   logic [MS10_W-1:0] lap_ms_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus_io.start_stop_btn),
      .pulse_o (ss_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus_io.lap_reset_btn),
      .pulse_o (lap_pulse)
   );

   // Next state; start/stop has priority so a coincident lap pulse is dropped.
   always_comb begin
      state_d = state_q;
      lap_cap = 1'b0;
      clr_d   = 1'b0;
      unique case (state_q)
         StIdle: if (ss_pulse) state_d = StRun;
         StRun: begin
            if (ss_pulse) begin
               state_d = StStop;
            end else if (lap_pulse) begin
               state_d = StLap;
               lap_cap = 1'b1;
            end
         end
         StLap: begin
            if (ss_pulse)       state_d = StStop;
            else if (lap_pulse) state_d = StRun;
         end
         StStop: begin
            if (ss_pulse) begin
               state_d = StRun;
            end else if (lap_pulse) begin
               state_d = StIdle;
               clr_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; clear is held through reset and its first following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         clr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   // Lap registers capture the live count on RUN->LAP only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_min_q <= '0;
         lap_sec_q <= '0;
         lap_ms_q  <= '0;
      end else if (lap_cap) begin
         lap_min_q <= bus_io.min_i;
         lap_sec_q <= bus_io.sec_i;
         lap_ms_q  <= bus_io.ms_10_i;
      end
   end

   assign bus_io.state_o   = state_q;
   assign bus_io.cnt_en_o  = (state_q == StRun) || (state_q == StLap);
   assign bus_io.cnt_clr_o = clr_q;
   assign bus_io.min_o     = (state_q == StLap) ? lap_min_q : bus_io.min_i;
   assign bus_io.sec_o     = (state_q == StLap) ? lap_sec_q : bus_io.sec_i;
   assign bus_io.ms_10_o   = (state_q == StLap) ? lap_ms_q  : bus_io.ms_10_i;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scenario bench for counter_ctrl with DEBOUNCE_CYCLES=4.
module tb_counter_ctrl;

   localparam int unsigned Db = 4;
   localparam logic [1:0] SIdle = 2'd0, SRun = 2'd1, SLap = 2'd2, SStop = 2'd3;

   typedef struct packed {
      logic [1:0] st;
      logic       en;
      logic       clr;
      logic [5:0] mn;
      logic [5:0] sc;
      logic [6:0] ms;
   } snap_t;

   typedef struct {
      string name;
      snap_t v;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    total = 0;
   int    bad = 0;
   exp_t  sb[$];
   exp_t  e;
   logic [5:0] m_lap_min = '0;
   logic [5:0] m_lap_sec = '0;
   logic [6:0] m_lap_ms  = '0;

   counter_ctrl_if bus ();

   counter_ctrl #(.DEBOUNCE_CYCLES(Db)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   function automatic snap_t obs();
      snap_t o;
      o.st  = bus.state_o;
      o.en  = bus.cnt_en_o;
      o.clr = bus.cnt_clr_o;
      o.mn  = bus.min_o;
      o.sc  = bus.sec_o;
      o.ms  = bus.ms_10_o;
      return o;
   endfunction

   // Expected outputs for a given state and clear level.
   function automatic snap_t mk(logic [1:0] st, logic clr);
      snap_t s;
      s.st  = st;
      s.en  = (st == SRun) || (st == SLap);
      s.clr = clr;
      if (st == SLap) begin
         s.mn = m_lap_min; s.sc = m_lap_sec; s.ms = m_lap_ms;
      end else begin
         s.mn = bus.min_i; s.sc = bus.sec_i; s.ms = bus.ms_10_i;
      end
      return s;
   endfunction

   task automatic push(input string name, input snap_t v);
      exp_t x;
      x.name = name;
      x.v    = v;
      sb.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold(input logic ss, input logic lap);
      bus.start_stop_btn = ss;
      bus.lap_reset_btn  = lap;
   endtask

   task automatic set_live(input logic [5:0] mn, input logic [5:0] sc, input logic [6:0] ms);
      bus.min_i = mn; bus.sec_i = sc; bus.ms_10_i = ms;
   endtask

   task automatic test_reset();
      hold(1'b0, 1'b0);
      set_live(6'd5, 6'd6, 7'd7);
      rst = 1'b1;
      tick(3);
      push("reset_hold", mk(SIdle, 1'b1));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      rst = 1'b0;
      #1;
      push("reset_clr_first", mk(SIdle, 1'b1));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(1);
      push("reset_clr_end", mk(SIdle, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(10);
   endtask

   task automatic test_glitch();
      hold(1'b1, 1'b0);
      tick(3);
      hold(1'b0, 1'b0);
      tick(12);
      push("glitch_idle", mk(SIdle, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b1);
      tick(10);
      hold(1'b0, 1'b0);
      tick(8);
      push("idle_lap_ignored", mk(SIdle, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
   endtask

   // Raw rise sampled at the first posedge; state must change on the 7th edge after.
   task automatic test_start();
      hold(1'b1, 1'b0);
      push("start_pre", mk(SIdle, 1'b0));
      push("start_post", mk(SRun, 1'b0));
      tick(Db + 3);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(2);
      hold(1'b0, 1'b0);
      tick(8);
      push("start_held_run", mk(SRun, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
   endtask

   task automatic test_lap();
      set_live(6'd1, 6'd23, 7'd45);
      hold(1'b0, 1'b1);
      m_lap_min = 6'd1; m_lap_sec = 6'd23; m_lap_ms = 7'd45;
      push("lap_enter", mk(SLap, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      set_live(6'd2, 6'd34, 7'd56);
      push("lap_frozen", mk(SLap, 1'b0));
      tick(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
      push("lap_still_frozen", mk(SLap, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b1);
      push("lap_release", mk(SRun, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
   endtask

   task automatic test_stop_clear();
      hold(1'b1, 1'b0);
      push("stop_enter", mk(SStop, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
      hold(1'b0, 1'b1);
      push("stop_pre_clear", mk(SStop, 1'b0));
      push("idle_clr_pulse", mk(SIdle, 1'b1));
      push("idle_clr_done", mk(SIdle, 1'b0));
      tick(Db + 3);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
   endtask

   task automatic test_both();
      hold(1'b1, 1'b0);
      push("both_setup_run", mk(SRun, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
      set_live(6'd3, 6'd4, 7'd5);
      hold(1'b1, 1'b1);
      push("both_to_stop", mk(SStop, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
      hold(1'b1, 1'b0);
      push("stop_resume_run", mk(SRun, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
   endtask

   task automatic test_reset_in_lap();
      set_live(6'd9, 6'd10, 7'd11);
      hold(1'b0, 1'b1);
      m_lap_min = 6'd9; m_lap_sec = 6'd10; m_lap_ms = 7'd11;
      push("rl_lap", mk(SLap, 1'b0));
      tick(Db + 4);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
      hold(1'b1, 1'b0);
      tick(3);
      rst = 1'b1;
      #1;
      m_lap_min = '0; m_lap_sec = '0; m_lap_ms = '0;
      push("rl_reset_idle", mk(SIdle, 1'b1));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(2);
      rst = 1'b0;
      tick(12);
      push("rl_held_no_pulse", mk(SIdle, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(15);
      push("rl_release_no_pulse", mk(SIdle, 1'b0));
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b1, 1'b0);
      push("rl_rearm_pre", mk(SIdle, 1'b0));
      push("rl_rearm_run", mk(SRun, 1'b0));
      tick(Db + 3);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      tick(1);
      e = sb.pop_front(); total++;
      if (obs() !== e.v) begin bad++; $display("FAIL %s: got %p want %p", e.name, obs(), e.v); end
      hold(1'b0, 1'b0);
      tick(8);
   endtask

   initial begin
      hold(1'b0, 1'b0);
      set_live('0, '0, '0);
      @(negedge clk);
      test_reset();
      test_glitch();
      test_start();
      test_lap();
      test_stop_clear();
      test_both();
      test_reset_in_lap();
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20: consecutive stable clk cycles a synchronized button level must hold before it is accepted.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_stop_btn  input  1  raw, asynchronous start/stop button, active-high.
REQ-005 lap_reset_btn  input  1  raw, asynchronous lap/reset button, active-high.
REQ-006 min_i / sec_i / ms_10_i  input  6/6/7  live count from counter_core.
REQ-007 cnt_en_o  output  1  count enable to counter_core.
REQ-008 cnt_clr_o  output  1  one-cycle synchronous clear pulse to counter_core.
REQ-009 min_o / sec_o / ms_10_o  output  6/6/7  display value, either live or lap-frozen.
REQ-010 state_o  output  2  current FSM state encoding: IDLE=0, RUN=1, LAP=2, STOP=3.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized value; any disagreement restarts the count.
REQ-012 A one-cycle press pulse SHALL fire on each 0->1 transition of the accepted level; releases and held levels generate nothing.
REQ-013 The press pulse SHALL assert exactly DEBOUNCE_CYCLES+2 cycles after a clean raw rise sampled at an edge; state changes on the following edge.
REQ-014 IDLE: start_stop press -> RUN; lap_reset press ignored.
REQ-015 RUN: start_stop press -> STOP; lap_reset press -> LAP, capturing min_i/sec_i/ms_10_i into lap registers on the same edge.
REQ-016 LAP: lap_reset press -> RUN (display released); start_stop press -> STOP (display released, counting halts).
REQ-017 STOP: start_stop press -> RUN (resume, no clear); lap_reset press -> IDLE with cnt_clr_o high for exactly the first IDLE cycle.
REQ-018 Simultaneous start_stop and lap_reset pulses: start_stop SHALL win; lap_reset pulse is discarded.
REQ-019 cnt_en_o SHALL be 1 exactly when state is RUN or LAP (decoded from the state register, no extra latency).
REQ-020 min_o/sec_o/ms_10_o SHALL show the lap registers in LAP and the live inputs in every other state.
REQ-021 Lap registers SHALL hold their value until the next RUN->LAP capture; no arithmetic is performed on them, and widths are passed through unchanged.

Reset
REQ-022 On rst assertion, at any point (including mid-debounce or in LAP), state SHALL go to IDLE, cnt_en_o=0, cnt_clr_o=1, debounce counters/accepted levels/synchronizers=0, lap registers=0.
REQ-023 cnt_clr_o SHALL remain 1 while rst is high and for the first cycle after deassertion, then 0; no press pulse SHALL be generated for a button already held through reset until it is released and pressed again.

Structure
REQ-024 Shared package counter_pkg SHALL hold the state enum and width constants MIN_W=6, SEC_W=6, MS10_W=7, used by counter_core and counter_ctrl.
REQ-025 Synchronizer, debounce counter and edge detector SHALL be one sub-module btn_debounce, instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then clean start_stop press -> state_o=RUN and cnt_en_o=1 exactly 7 cycles after the sampled raw rise.
REQ-027 Glitch of 3 cycles high on start_stop -> no pulse, state stays IDLE.
REQ-028 RUN with live count 01:23.45, lap press -> state LAP, outputs frozen at 1/23/45 while the live input advances, cnt_en_o stays 1; second lap press -> live display.
REQ-029 RUN -> start_stop -> STOP (cnt_en_o=0); lap press -> IDLE with cnt_clr_o high for exactly 1 cycle.
REQ-030 Both buttons pressed on the same cycle in RUN -> STOP, lap registers unchanged.
REQ-031 rst asserted in LAP with a debounce in progress -> immediate IDLE, cnt_clr_o=1, lap registers 0, no spurious pulse afterward.
